// File: rtl/tetris_input_pkg.sv
// rtl/tetris_input_pkg.sv - shared scan codes, FSM states and key enums for tetris_input_ctrl
//
// Purpose: PS/2 set-2 scan-code constants, prefix-FSM state enum, action
// enum and the scan-code-to-action map used by ps2_key_decoder.
// Optional feature: TETRIS_INPUT_WASD_EN adds the A/D/S/W alternate keys.
// Ports: none (package).
package tetris_input_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_ROT   = 8'h75;
  localparam logic [7:0] SC_DROP  = 8'h29;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_W     = 8'h1D;

  // Bit positions of each action in the held/pending vectors.
  localparam int IX_LEFT  = 0;
  localparam int IX_RIGHT = 1;
  localparam int IX_DOWN  = 2;
  localparam int IX_ROT   = 3;
  localparam int IX_DROP  = 4;

  typedef enum logic [1:0] {
    PFX_IDLE,
    PFX_EXT,
    PFX_BRK,
    PFX_EXT_BRK
  } pfx_state_e;

  // Encoding matches the IX_* bit positions so a key can be used as a shift.
  typedef enum logic [2:0] {
    KEY_LEFT   = 3'd0,
    KEY_RIGHT  = 3'd1,
    KEY_DOWN   = 3'd2,
    KEY_ROTATE = 3'd3,
    KEY_DROP   = 3'd4
  } key_e;

  typedef struct packed {
    logic valid;
`ifdef TETRIS_INPUT_WASD_EN
    logic alt;     // key came from the WASD cluster rather than arrows/space
`endif
    key_e key;
  } key_map_t;

  function automatic key_map_t map_code(input logic [7:0] code, input logic ext);
    key_map_t m;
    m.valid = 1'b1;
`ifdef TETRIS_INPUT_WASD_EN
    m.alt   = 1'b0;
`endif
    m.key   = KEY_LEFT;
    if (ext) begin
      case (code)
        SC_LEFT:  m.key = KEY_LEFT;
        SC_RIGHT: m.key = KEY_RIGHT;
        SC_DOWN:  m.key = KEY_DOWN;
        SC_ROT:   m.key = KEY_ROTATE;
        default:  m.valid = 1'b0;
      endcase
    end else begin
      case (code)
        SC_DROP: m.key = KEY_DROP;
`ifdef TETRIS_INPUT_WASD_EN
        SC_A: begin m.key = KEY_LEFT;   m.alt = 1'b1; end
        SC_D: begin m.key = KEY_RIGHT;  m.alt = 1'b1; end
        SC_S: begin m.key = KEY_DOWN;   m.alt = 1'b1; end
        SC_W: begin m.key = KEY_ROTATE; m.alt = 1'b1; end
`endif
        default: m.valid = 1'b0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 prefix FSM and key map producing make/break events
//
// Purpose: tracks E0/F0 prefixes and turns each terminating byte into a
// one-cycle key event. The event is combinational from scan_valid so the
// consumer can register it on the same edge the byte arrives.
// Optional feature: TETRIS_INPUT_WASD_EN adds ev_alt and the WASD codes.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   scan_valid         strobe, scan_code holds a received byte
//   scan_code[7:0]     received PS/2 byte
//   ev_valid           one-cycle strobe: a mapped key was made or broken
//   ev_key             which action the key maps to
//   ev_make            1 = make (press), 0 = break (release)
//   ev_alt             (WASD build only) event came from the WASD cluster
module ps2_key_decoder
  import tetris_input_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  output logic       ev_valid,
  output key_e       ev_key,
  output logic       ev_make
`ifdef TETRIS_INPUT_WASD_EN
  ,
  output logic       ev_alt
`endif
);

  pfx_state_e state, state_n;
  key_map_t   map;

  always_ff @(posedge clk) begin
    if (rst) state <= PFX_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    ev_valid = 1'b0;
    ev_make  = 1'b0;
    map      = map_code(scan_code, (state == PFX_EXT) || (state == PFX_EXT_BRK));
    if (scan_valid) begin
      case (state)
        PFX_IDLE: begin
          if (scan_code == SC_EXT)      state_n = PFX_EXT;
          else if (scan_code == SC_BRK) state_n = PFX_BRK;
          else begin
            state_n  = PFX_IDLE;
            ev_valid = map.valid;
            ev_make  = 1'b1;
          end
        end
        PFX_EXT: begin
          if (scan_code == SC_BRK)      state_n = PFX_EXT_BRK;
          else if (scan_code == SC_EXT) state_n = PFX_EXT;
          else begin
            state_n  = PFX_IDLE;
            ev_valid = map.valid;
            ev_make  = 1'b1;
          end
        end
        // Any byte after a break prefix terminates it, even a stray prefix.
        PFX_BRK, PFX_EXT_BRK: begin
          state_n  = PFX_IDLE;
          ev_valid = map.valid;
          ev_make  = 1'b0;
        end
        default: state_n = PFX_IDLE;
      endcase
    end
    ev_key = map.key;
`ifdef TETRIS_INPUT_WASD_EN
    ev_alt = map.alt;
`endif
  end

endmodule

// File: rtl/tetris_input_ctrl.sv
// rtl/tetris_input_ctrl.sv - keyboard-to-action front end with DAS/auto-repeat for tetris_game
//
// Purpose: turns decoded key events into pending-action levels. Tracks held
// keys, applies delayed auto-shift and auto-repeat on the game tick, and
// holds each action until tetris_game consumes it on a tick.
// Optional feature: TETRIS_INPUT_WASD_EN maps A/D/S/W onto the arrow actions;
// each action is then held while either of its two sources is held.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   tick_game            one-cycle game tick; consumes pending actions
//   freeze               game over / paused: pending forced low, counters hold
//   scan_valid           strobe, scan_code holds a received PS/2 byte
//   scan_code[7:0]       received PS/2 byte
//   key_left/right/down/rotate/drop  registered pending-action levels
module tetris_input_ctrl
  import tetris_input_pkg::*;
#(
  parameter int DAS_TICKS  = 10,
  parameter int ARR_TICKS  = 3,
  parameter int SOFT_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_game,
  input  logic       freeze,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  output logic       key_left,
  output logic       key_right,
  output logic       key_down,
  output logic       key_rotate,
  output logic       key_drop
);

  localparam logic [7:0] DAS_V  = 8'(DAS_TICKS);
  localparam logic [7:0] ARR_V  = 8'(ARR_TICKS);
  localparam logic [7:0] SOFT_V = 8'(SOFT_TICKS);

  logic ev_valid;
  key_e ev_key;
  logic ev_make;

  logic [4:0] src_a, src_a_n;   // arrow / space source of each action
`ifdef TETRIS_INPUT_WASD_EN
  logic       ev_alt;
  logic [4:0] src_b, src_b_n;   // WASD source of each action
`endif
  logic [4:0] held, held_n, ev_onehot, press, rel, arm, pend, pend_n;
  logic [7:0] dir_cnt, dir_cnt_n, down_cnt, down_cnt_n;
  logic       last_dir, last_dir_n;   // 0 = left, 1 = right
  logic       run, dir_held, rel_last, other_held_n;

  ps2_key_decoder u_dec (
    .clk        (clk),
    .rst        (rst),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .ev_valid   (ev_valid),
    .ev_key     (ev_key),
    .ev_make    (ev_make)
`ifdef TETRIS_INPUT_WASD_EN
    ,
    .ev_alt     (ev_alt)
`endif
  );

  // Held-state update. Press/release are the logical 0->1 / 1->0 edges of the
  // held vector, which automatically ignores typematic makes and stray breaks.
  always_comb begin
    ev_onehot = ev_valid ? (5'b00001 << ev_key) : 5'b00000;
    src_a_n   = src_a;
`ifdef TETRIS_INPUT_WASD_EN
    src_b_n = src_b;
    if (ev_alt) src_b_n = ev_make ? (src_b | ev_onehot) : (src_b & ~ev_onehot);
    else        src_a_n = ev_make ? (src_a | ev_onehot) : (src_a & ~ev_onehot);
    held   = src_a | src_b;
    held_n = src_a_n | src_b_n;
`else
    src_a_n = ev_make ? (src_a | ev_onehot) : (src_a & ~ev_onehot);
    held    = src_a;
    held_n  = src_a_n;
`endif
    press = held_n & ~held;
    rel   = held & ~held_n;
  end

  // Repeat timers. Tick-driven decrement/arming is evaluated on the current
  // state first; a press or release in the same cycle then overrides the load.
  always_comb begin
    run          = tick_game & ~freeze;
    dir_cnt_n    = dir_cnt;
    down_cnt_n   = down_cnt;
    last_dir_n   = last_dir;
    arm          = 5'b00000;
    dir_held     = last_dir ? held[IX_RIGHT] : held[IX_LEFT];
    rel_last     = last_dir ? rel[IX_RIGHT]  : rel[IX_LEFT];
    other_held_n = last_dir ? held_n[IX_LEFT] : held_n[IX_RIGHT];

    if (run && dir_held) begin
      if (dir_cnt == 8'd1) begin
        if (last_dir) arm[IX_RIGHT] = 1'b1;
        else          arm[IX_LEFT]  = 1'b1;
        dir_cnt_n = ARR_V;
      end else begin
        dir_cnt_n = dir_cnt - 8'd1;
      end
    end

    if (run && held[IX_DOWN]) begin
      if (down_cnt == 8'd1) begin
        arm[IX_DOWN] = 1'b1;
        down_cnt_n   = SOFT_V;
      end else begin
        down_cnt_n = down_cnt - 8'd1;
      end
    end

    // The most recently pressed direction owns the shared counter.
    if (press[IX_LEFT]) begin
      dir_cnt_n  = DAS_V;
      last_dir_n = 1'b0;
    end else if (press[IX_RIGHT]) begin
      dir_cnt_n  = DAS_V;
      last_dir_n = 1'b1;
    end else if (rel_last) begin
      // Hand the counter to the other direction if it is still down.
      if (other_held_n) begin
        last_dir_n = ~last_dir;
        dir_cnt_n  = DAS_V;
      end else begin
        dir_cnt_n = 8'd0;
      end
    end

    if (press[IX_DOWN])    down_cnt_n = SOFT_V;
    else if (rel[IX_DOWN]) down_cnt_n = 8'd0;

    // Set wins over consumption; freeze overrides everything.
    if (freeze) pend_n = 5'b00000;
    else        pend_n = (tick_game ? 5'b00000 : pend) | press | arm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_a    <= 5'b00000;
`ifdef TETRIS_INPUT_WASD_EN
      src_b    <= 5'b00000;
`endif
      pend     <= 5'b00000;
      dir_cnt  <= 8'd0;
      down_cnt <= 8'd0;
      last_dir <= 1'b0;
    end else begin
      src_a    <= src_a_n;
`ifdef TETRIS_INPUT_WASD_EN
      src_b    <= src_b_n;
`endif
      pend     <= pend_n;
      dir_cnt  <= dir_cnt_n;
      down_cnt <= down_cnt_n;
      last_dir <= last_dir_n;
    end
  end

  assign key_left   = pend[IX_LEFT];
  assign key_right  = pend[IX_RIGHT];
  assign key_down   = pend[IX_DOWN];
  assign key_rotate = pend[IX_ROT];
  assign key_drop   = pend[IX_DROP];

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// tb/tb_tetris_input_ctrl.sv - directed self-checking bench for tetris_input_ctrl
module tb_tetris_input_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_game;
  logic       freeze;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       key_left, key_right, key_down, key_rotate, key_drop;
  logic [4:0] keys;

  int checks   = 0;
  int failures = 0;

  assign keys = {key_drop, key_rotate, key_down, key_right, key_left};

  always #5 clk = ~clk;

  tetris_input_ctrl #(
    .DAS_TICKS  (10),
    .ARR_TICKS  (3),
    .SOFT_TICKS (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_game  (tick_game),
    .freeze     (freeze),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .key_left   (key_left),
    .key_right  (key_right),
    .key_down   (key_down),
    .key_rotate (key_rotate),
    .key_drop   (key_drop)
  );

  // All stimulus tasks start and end on a falling edge.
  task automatic send(input logic [7:0] c);
    scan_code  = c;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
    scan_code  = 8'h00;
  endtask

  task automatic ext_make(input logic [7:0] c);
    send(8'hE0);
    send(c);
  endtask

  task automatic ext_break(input logic [7:0] c);
    send(8'hE0);
    send(8'hF0);
    send(c);
  endtask

  // seen = action levels present at the tick edge, i.e. what gets consumed.
  task automatic tick(output logic [4:0] seen);
    seen      = keys;
    tick_game = 1'b1;
    @(negedge clk);
    tick_game = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [4:0] s;
    rst = 1'b1; tick_game = 1'b0; freeze = 1'b0; scan_valid = 1'b0; scan_code = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (keys !== 5'b00000) begin failures++; $display("FAIL reset_outputs got=%b want=%b", keys, 5'b00000); end
    // Reset after E0 must drop the prefix: a bare 74 is unmapped.
    send(8'hE0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(8'h74);
    checks++;
    if (keys !== 5'b00000) begin failures++; $display("FAIL reset_mid_prefix got=%b want=%b", keys, 5'b00000); end
    tick(s);
  endtask

  task automatic test_tap();
    logic [4:0] s;
    ext_make(8'h74);
    checks++;
    if (keys !== 5'b00010) begin failures++; $display("FAIL tap_set got=%b want=%b", keys, 5'b00010); end
    tick(s);
    checks++;
    if (s !== 5'b00010) begin failures++; $display("FAIL tap_consumed got=%b want=%b", s, 5'b00010); end
    checks++;
    if (keys !== 5'b00000) begin failures++; $display("FAIL tap_cleared got=%b want=%b", keys, 5'b00000); end
    ext_break(8'h74);
    tick(s);
  endtask

  task automatic test_das();
    logic [4:0]  s;
    logic [19:0] mask;
    int          cnt;
    mask = '0;
    cnt  = 0;
    ext_make(8'h6B);
    for (int i = 1; i <= 20; i++) begin
      tick(s);
      if (s[0]) begin mask[i-1] = 1'b1; cnt++; end
      if (i == 5 || i == 12) ext_make(8'h6B);
    end
    checks++;
    if (mask !== 20'h92401) begin failures++; $display("FAIL das_tick_pattern got=%h want=%h", mask, 20'h92401); end
    checks++;
    if (cnt != 5) begin failures++; $display("FAIL das_count got=%0d want=%0d", cnt, 5); end
    ext_break(8'h6B);
    tick(s);
    tick(s);
    checks++;
    if (keys !== 5'b00000) begin failures++; $display("FAIL das_after_release got=%b want=%b", keys, 5'b00000); end
  endtask

  task automatic test_short_tap();
    logic [4:0] s;
    int         cnt;
    cnt = 0;
    ext_make(8'h6B);
    ext_break(8'h6B);
    for (int i = 0; i < 15; i++) begin
      tick(s);
      if (s[0]) cnt++;
    end
    checks++;
    if (cnt != 1) begin failures++; $display("FAIL short_tap_count got=%0d want=%0d", cnt, 1); end
  endtask

  task automatic test_rotate_drop();
    logic [4:0] s;
    int         cd, cr;
    cd = 0;
    cr = 0;
    send(8'h29);
    for (int i = 0; i < 15; i++) begin
      tick(s);
      if (s[4]) cd++;
    end
    checks++;
    if (cd != 1) begin failures++; $display("FAIL drop_count got=%0d want=%0d", cd, 1); end
    send(8'hF0);
    send(8'h29);
    ext_make(8'h75);
    tick(s);
    if (s[3]) cr++;
    ext_break(8'h75);
    ext_make(8'h75);
    for (int i = 0; i < 5; i++) begin
      tick(s);
      if (s[3]) cr++;
    end
    checks++;
    if (cr != 2) begin failures++; $display("FAIL rotate_count got=%0d want=%0d", cr, 2); end
    ext_break(8'h75);
  endtask

  task automatic test_soft_drop();
    logic [4:0] s, acc;
    int         c;
    c   = 0;
    acc = '0;
    ext_make(8'h72);
    for (int i = 0; i < 6; i++) begin
      tick(s);
      if (s[2]) c++;
    end
    checks++;
    if (c != 6) begin failures++; $display("FAIL soft_drop_count got=%0d want=%0d", c, 6); end
    freeze = 1'b1;
    @(negedge clk);
    checks++;
    if (keys !== 5'b00000) begin failures++; $display("FAIL freeze_clear got=%b want=%b", keys, 5'b00000); end
    for (int i = 0; i < 3; i++) begin
      tick(s);
      acc = acc | s;
    end
    ext_make(8'h75);
    acc = acc | keys;
    checks++;
    if (acc !== 5'b00000) begin failures++; $display("FAIL freeze_hold got=%b want=%b", acc, 5'b00000); end
    ext_break(8'h75);
    ext_break(8'h72);
    freeze = 1'b0;
    tick(s);
    tick(s);
    checks++;
    if (keys !== 5'b00000) begin failures++; $display("FAIL freeze_release_tracked got=%b want=%b", keys, 5'b00000); end
  endtask

  task automatic test_arbitration();
    logic [4:0] s;
    int         cl, cr;
    ext_make(8'h6B);
    for (int i = 0; i < 4; i++) tick(s);
    ext_make(8'h74);
    checks++;
    if (keys !== 5'b00010) begin failures++; $display("FAIL arb_right_immediate got=%b want=%b", keys, 5'b00010); end
    cl = 0; cr = 0;
    for (int i = 0; i < 12; i++) begin
      tick(s);
      if (s[0]) cl++;
      if (s[1]) cr++;
    end
    checks++;
    if (cl != 0) begin failures++; $display("FAIL arb_left_stopped got=%0d want=%0d", cl, 0); end
    checks++;
    if (cr != 2) begin failures++; $display("FAIL arb_right_repeat got=%0d want=%0d", cr, 2); end
    ext_break(8'h74);
    cl = 0; cr = 0;
    for (int i = 0; i < 10; i++) begin
      tick(s);
      if (s[0]) cl++;
      if (s[1]) cr++;
    end
    checks++;
    if (cl != 0 || cr != 0) begin failures++; $display("FAIL arb_das_wait got=%0d/%0d want=0/0", cl, cr); end
    tick(s);
    checks++;
    if (s !== 5'b00001) begin failures++; $display("FAIL arb_left_resume got=%b want=%b", s, 5'b00001); end
    ext_break(8'h6B);
    tick(s);
    tick(s);
  endtask

  task automatic test_back_to_back();
    logic [4:0] s;
    send(8'hE0);
    scan_code  = 8'h74;
    scan_valid = 1'b1;
    tick_game  = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
    tick_game  = 1'b0;
    checks++;
    if (keys !== 5'b00010) begin failures++; $display("FAIL b2b_set_wins got=%b want=%b", keys, 5'b00010); end
    tick(s);
    checks++;
    if (s !== 5'b00010 || keys !== 5'b00000) begin
      failures++; $display("FAIL b2b_consume got=%b/%b want=%b/%b", s, keys, 5'b00010, 5'b00000);
    end
    ext_break(8'h74);
  endtask

  task automatic test_wasd();
    logic [4:0] s;
    int         cl;
`ifdef TETRIS_INPUT_WASD_EN
    send(8'h1C);
    checks++;
    if (keys !== 5'b00001) begin failures++; $display("FAIL wasd_a_press got=%b want=%b", keys, 5'b00001); end
    tick(s);
    ext_make(8'h6B);
    checks++;
    if (keys !== 5'b00000) begin failures++; $display("FAIL wasd_or_no_press got=%b want=%b", keys, 5'b00000); end
    send(8'hF0);
    send(8'h1C);
    cl = 0;
    for (int i = 0; i < 10; i++) begin
      tick(s);
      if (s[0]) cl++;
    end
    checks++;
    if (cl != 1) begin failures++; $display("FAIL wasd_or_still_held got=%0d want=%0d", cl, 1); end
    ext_break(8'h6B);
    tick(s);
`else
    send(8'h1C);
    checks++;
    if (keys !== 5'b00000) begin failures++; $display("FAIL wasd_ignored got=%b want=%b", keys, 5'b00000); end
    send(8'hF0);
    send(8'h1C);
    cl = 0;
    tick(s);
    if (s[0]) cl++;
    checks++;
    if (cl != 0) begin failures++; $display("FAIL wasd_ignored_tick got=%0d want=%0d", cl, 0); end
`endif
  endtask

  initial begin
    test_reset();
    test_tap();
    test_das();
    test_short_tap();
    test_rotate_drop();
    test_soft_drop();
    test_arbitration();
    test_back_to_back();
    test_wasd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tetris_input_ctrl.md
# tetris_input_ctrl

Keyboard-to-action front end sitting directly upstream of `tetris_game`. It:
- decodes PS/2 set-2 scan bytes, already assembled by the PS/2 receiver, into held-key state;
- applies delayed auto-shift (DAS) and auto-repeat on the `tick_game` time base;
- presents `key_left/right/down/rotate/drop` as pending-action levels that `tetris_game` consumes on its tick.

## Interface
Parameters:
- `DAS_TICKS`, 10: ticks a left/right key is held before the first auto-repeat (1..255).
- `ARR_TICKS`, 3: ticks between subsequent left/right repeats (1..255).
- `SOFT_TICKS`, 1: ticks between soft-drop repeats while down is held (1..255).

Ports:
- `clk` in 1: system clock, single domain.
- `rst` in 1: synchronous, active-high reset.
- `tick_game` in 1: one-cycle game tick strobe, the same signal that drives `tetris_game`.
- `freeze` in 1: high while game over or paused; suppresses all actions.
- `scan_valid` in 1: one-cycle strobe; `scan_code` is valid.
- `scan_code` in 8: received PS/2 byte.
- `key_left`, `key_right`, `key_down`, `key_rotate`, `key_drop` out 1 each: pending action, held until consumed by a tick.

## Operation
- Prefix FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
  - IDLE: E0 goes to EXT; F0 goes to BRK.
  - EXT: F0 goes to EXT_BRK; E0 stays in EXT.
  - Any other byte is decoded as make (IDLE/EXT) or break (BRK/EXT_BRK), then the FSM returns to IDLE.
- Key map, extended: 6B left, 74 right, 72 down, 75 rotate. Non-extended: 29 (space) drop. Unmapped codes are ignored, but the FSM still returns to IDLE.
- Held bits `h_l`, `h_r`, `h_d`, `h_rot`, `h_drop`.
  - A make on a key whose held bit is already set (keyboard typematic) is ignored.
  - A break on a key that is not held is ignored.
- Press event (make on a non-held key):
  - Sets the held bit and sets the matching pending bit.
  - Left/right: loads `dir_cnt` with `DAS_TICKS` and records `last_dir`.
  - Down: loads `down_cnt` with `SOFT_TICKS`.
- Left/right arbitration: if both are held, only `last_dir` auto-repeats. Releasing `last_dir` while the other is still held switches `last_dir` to the other key and reloads `dir_cnt` with `DAS_TICKS`.
- Repeat, on each `tick_game` while the key is held and `freeze` is low:
  - If the counter is 1: set pending, then reload (`ARR_TICKS` for direction, `SOFT_TICKS` for down).
  - Otherwise decrement the counter.
- Rotate and drop never auto-repeat; each requires a fresh make.
- Release clears the held bit and its counter. It does not clear a pending bit, so a tap shorter than one tick is still delivered.
- Consumption: every pending bit clears on the edge where `tick_game` is 1. If a set (press or repeat) occurs on the same edge, the set wins and the bit stays 1 for the next tick.
- `freeze` high:
  - Pending bits are forced to 0 and no arming occurs.
  - Decode and held tracking continue.
  - Counters hold their value.

## Timing
- Reset: all outputs 0, FSM in IDLE, held bits 0, counters 0, `last_dir` = left.
- `scan_valid` at cycle t sets pending, visible on the output at t+1.
- Registered outputs only; no combinational path from input to output.
- Press on tick k: action is consumed at the first tick after the press. The first auto-repeat arms on tick k+`DAS_TICKS` and is consumed at the following tick; further repeats arm every `ARR_TICKS` ticks.
- `scan_valid` and `tick_game` in the same cycle: both take effect, and the set-wins rule applies.
- Reset mid-sequence (e.g. after E0): FSM returns to IDLE; the next byte is decoded from scratch.

## Configuration
- `TETRIS_INPUT_WASD_EN` defined: additionally map the non-extended codes 1C (A) left, 23 (D) right, 1B (S) down, 1D (W) rotate.
  - These share held state with the arrow keys: they form a logical OR of the two sources, and a key counts as released only when both its sources are released.
- Macro undefined: these codes are ignored like any other unmapped code.

## Structure
- Package `tetris_input_pkg`:
  - scan-code localparams;
  - prefix-FSM state enum;
  - `key_e` action enum (LEFT, RIGHT, DOWN, ROTATE, DROP).
- Sub-module `ps2_key_decoder`: prefix FSM plus key map. It outputs a one-cycle `ev_valid`, `ev_key` (`key_e`) and `ev_make`.
- The top level holds the held bits, counters, arbitration and pending registers.

## Test plan
1. Reset, then feed E0 74 with no tick: `key_right` = 1 from the next cycle. One tick later, `key_right` = 0 and all other outputs are 0.
2. E0 6B, then 20 ticks with no break, defaults: `key_left` is consumed at tick 1, then 11, 14, 17, 20, so 5 actions total. Extra E0 6B typematic bytes add none.
3. E0 6B then E0 F0 6B within one tick period: exactly one `key_left` consumed, no repeats.
4. 29 held for 15 ticks: exactly one `key_drop`. E0 75, break, E0 75: two `key_rotate`.
5. E0 72 held with `SOFT_TICKS` = 1: `key_down` is 1 at every tick. Assert `freeze`: `key_down` drops to 0 at the next cycle and stays 0.
6. Hold left, then press right: right pulses immediately and left repeats stop. Release right: left resumes repeating after `DAS_TICKS` ticks. With the macro defined, 1C behaves identically to E0 6B.
